// File: rtl/date_pkg.sv
// date_pkg: shared constants and helpers for the calendar date counter.
//   M_*            : BCD month codes with irregular lengths (plus January/December).
//   digit_ok       : BCD digit is in 0..9.
//   bcd16_ok       : all four digits of a 16-bit BCD word are in 0..9.
//   pair_div4      : two-digit BCD value tens:ones is divisible by 4.
//   days_in_month  : month length in BCD for a BCD month and leap flag.
//   bcd_inc2       : two-digit BCD increment (no wrap handling; callers bound it).
package date_pkg;

  localparam logic [7:0] M_JAN = 8'h01;
  localparam logic [7:0] M_FEB = 8'h02;
  localparam logic [7:0] M_APR = 8'h04;
  localparam logic [7:0] M_JUN = 8'h06;
  localparam logic [7:0] M_SEP = 8'h09;
  localparam logic [7:0] M_NOV = 8'h11;
  localparam logic [7:0] M_DEC = 8'h12;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  function automatic logic bcd16_ok(input logic [15:0] v);
    return digit_ok(v[15:12]) && digit_ok(v[11:8]) && digit_ok(v[7:4]) && digit_ok(v[3:0]);
  endfunction

  // 10*tens is 0 mod 4 for even tens and 2 mod 4 for odd tens, so the ones
  // digit must supply the complementary residue.
  function automatic logic pair_div4(input logic [3:0] tens, input logic [3:0] ones);
    logic ones_0mod4;
    logic ones_2mod4;
    ones_0mod4 = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    ones_2mod4 = (ones == 4'd2) || (ones == 4'd6);
    return (ones_0mod4 && !tens[0]) || (ones_2mod4 && tens[0]);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
    logic [7:0] dim;
    case (month)
      M_FEB:                      dim = leap ? 8'h29 : 8'h28;
      M_APR, M_JUN, M_SEP, M_NOV: dim = 8'h30;
      default:                    dim = 8'h31;
    endcase
    return dim;
  endfunction

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/leap_year_gregorian.sv
// leap_year_gregorian: combinational Gregorian leap test on a 4-digit BCD year.
//   year    in  16 : BCD year, thousands:hundreds:tens:ones.
//   is_leap out  1 : year divisible by 4, excluding centuries not divisible by 400.
// A century year (tens:ones = 00) is divisible by 400 exactly when
// thousands:hundreds is divisible by 4, so the same pair test serves both cases.
module leap_year_gregorian
  import date_pkg::*;
(
  input  logic [15:0] year,
  output logic        is_leap
);

  logic century;

  assign century = (year[7:0] == 8'h00);
  assign is_leap = century ? pair_div4(year[15:12], year[11:8])
                           : pair_div4(year[7:4], year[3:0]);

endmodule

// File: rtl/date_counter.sv
// date_counter: BCD calendar date register advanced by one day per day_tick,
// with a validated load port.
//   clk, rst          : clock and asynchronous active-high reset.
//   day_tick          : one-cycle strobe, advance one day.
//   set_en            : load request (each high cycle is a separate request);
//                       wins over day_tick, which is then dropped.
//   set_year/month/day: BCD date to load.
//   set_ack / set_err : one-cycle pulse, load accepted / rejected.
//   year, month, day  : current date, BCD, registered.
//   is_leap           : current year is leap (combinational from year).
//   year_wrap         : one-cycle pulse when the year rolls from all-9s to all-0s.
module date_counter
  import date_pkg::*;
#(
  parameter int          YEAR_DIGITS = 4,
  parameter logic [3:0]  THOUSANDS   = 4'h2,
  parameter logic [15:0] RESET_YEAR  = 16'h2000,
  parameter logic [7:0]  RESET_MONTH = 8'h01,
  parameter logic [7:0]  RESET_DAY   = 8'h01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     day_tick,
  input  logic                     set_en,
  input  logic [4*YEAR_DIGITS-1:0] set_year,
  input  logic [7:0]               set_month,
  input  logic [7:0]               set_day,
  output logic                     set_ack,
  output logic                     set_err,
  output logic [4*YEAR_DIGITS-1:0] year,
  output logic [7:0]               month,
  output logic [7:0]               day,
  output logic                     is_leap,
  output logic                     year_wrap
);

  localparam int YW = 4 * YEAR_DIGITS;

  // Reset date as a full 4-digit year, for elaboration-time validation.
  localparam logic [15:0] RST_FULL  = (YEAR_DIGITS == 4) ? RESET_YEAR
                                                         : {THOUSANDS, RESET_YEAR[11:0]};
  localparam logic        RST_LEAP  = (RST_FULL[7:0] == 8'h00)
                                      ? pair_div4(RST_FULL[15:12], RST_FULL[11:8])
                                      : pair_div4(RST_FULL[7:4], RST_FULL[3:0]);
  localparam logic [7:0]  RST_DIM   = days_in_month(RESET_MONTH, RST_LEAP);
  localparam logic        RST_VALID = bcd16_ok(RST_FULL)
                                      && digit_ok(RESET_MONTH[7:4]) && digit_ok(RESET_MONTH[3:0])
                                      && digit_ok(RESET_DAY[7:4]) && digit_ok(RESET_DAY[3:0])
                                      && (RESET_MONTH >= M_JAN) && (RESET_MONTH <= M_DEC)
                                      && (RESET_DAY >= 8'h01) && (RESET_DAY <= RST_DIM);

  if (YEAR_DIGITS != 3 && YEAR_DIGITS != 4) begin : g_bad_digits
    $error("date_counter: YEAR_DIGITS must be 3 or 4");
  end
  if (!RST_VALID) begin : g_bad_reset
    $error("date_counter: RESET_YEAR/RESET_MONTH/RESET_DAY is not a valid date");
  end

  logic [YW-1:0] year_reg, year_next;
  logic [7:0]    month_reg, month_next;
  logic [7:0]    day_reg, day_next;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic          wrap_reg, wrap_next;

  // Leap evaluation always works on four digits; a 3-digit year borrows THOUSANDS.
  logic [15:0] cur_year_full;
  logic [15:0] set_year_full;

  if (YEAR_DIGITS == 4) begin : g_year_native
    assign cur_year_full = year_reg;
    assign set_year_full = set_year;
  end else begin : g_year_padded
    assign cur_year_full = {THOUSANDS, year_reg};
    assign set_year_full = {THOUSANDS, set_year};
  end

  logic cur_leap;
  logic set_leap;

  leap_year_gregorian u_cur_leap (
    .year    (cur_year_full),
    .is_leap (cur_leap)
  );

  leap_year_gregorian u_set_leap (
    .year    (set_year_full),
    .is_leap (set_leap)
  );

  // Year increment: ripple carry through the digits, carry-in fixed at 1.
  // The carry out of the top digit is the all-9s rollover.
  logic [YEAR_DIGITS:0]   year_carry;
  logic [YW-1:0]          year_inc;
  logic [YEAR_DIGITS-1:0] set_year_digit_ok;

  assign year_carry[0] = 1'b1;

  for (genvar gi = 0; gi < YEAR_DIGITS; gi++) begin : g_year_digit
    logic [3:0] digit;
    assign digit                    = year_reg[4*gi +: 4];
    assign year_inc[4*gi +: 4]      = !year_carry[gi]  ? digit :
                                      (digit == 4'd9)  ? 4'd0  : digit + 4'd1;
    assign year_carry[gi+1]         = year_carry[gi] && (digit == 4'd9);
    assign set_year_digit_ok[gi]    = digit_ok(set_year[4*gi +: 4]);
  end

  logic [7:0] cur_dim;
  logic [7:0] set_dim;
  logic       set_valid;

  assign cur_dim = days_in_month(month_reg, cur_leap);
  assign set_dim = days_in_month(set_month, set_leap);

  // Digit checks first make the numeric BCD range compares meaningful.
  assign set_valid = (&set_year_digit_ok)
                     && digit_ok(set_month[7:4]) && digit_ok(set_month[3:0])
                     && digit_ok(set_day[7:4]) && digit_ok(set_day[3:0])
                     && (set_month >= M_JAN) && (set_month <= M_DEC)
                     && (set_day >= 8'h01) && (set_day <= set_dim);

  always_comb begin
    year_next  = year_reg;
    month_next = month_reg;
    day_next   = day_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    wrap_next  = 1'b0;
    if (set_en) begin
      if (set_valid) begin
        year_next  = set_year;
        month_next = set_month;
        day_next   = set_day;
        ack_next   = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end else if (day_tick) begin
      if (day_reg < cur_dim) begin
        day_next = bcd_inc2(day_reg);
      end else begin
        day_next = 8'h01;
        if (month_reg == M_DEC) begin
          month_next = M_JAN;
          year_next  = year_inc;
          wrap_next  = year_carry[YEAR_DIGITS];
        end else begin
          month_next = bcd_inc2(month_reg);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      year_reg  <= RESET_YEAR[YW-1:0];
      month_reg <= RESET_MONTH;
      day_reg   <= RESET_DAY;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      year_reg  <= year_next;
      month_reg <= month_next;
      day_reg   <= day_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign year      = year_reg;
  assign month     = month_reg;
  assign day       = day_reg;
  assign set_ack   = ack_reg;
  assign set_err   = err_reg;
  assign year_wrap = wrap_reg;
  assign is_leap   = cur_leap;

endmodule

// File: tb/tb_date_counter.sv
// tb_date_counter: self-checking bench for date_counter.
// A table of directed vectors, hand sequences for rollover, held set_en and
// reset-during-activity, a 3-digit-year instance, then randomized traffic
// checked against an integer calendar model.
module tb_date_counter;

  logic        clk;
  logic        rst;
  logic        day_tick, set_en;
  logic [15:0] set_year;
  logic [7:0]  set_month, set_day;
  logic        set_ack, set_err, is_leap, year_wrap;
  logic [15:0] year;
  logic [7:0]  month, day;

  logic        day_tick3, set_en3;
  logic [11:0] set_year3;
  logic [7:0]  set_month3, set_day3;
  logic        set_ack3, set_err3, is_leap3, year_wrap3;
  logic [11:0] year3;
  logic [7:0]  month3, day3;

  int n_cmp = 0;
  int n_bad = 0;

  date_counter u_dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .set_en(set_en),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_ack(set_ack), .set_err(set_err), .year(year), .month(month),
    .day(day), .is_leap(is_leap), .year_wrap(year_wrap)
  );

  date_counter #(.YEAR_DIGITS(3), .THOUSANDS(4'h2), .RESET_YEAR(16'h0000)) u_dut3 (
    .clk(clk), .rst(rst), .day_tick(day_tick3), .set_en(set_en3),
    .set_year(set_year3), .set_month(set_month3), .set_day(set_day3),
    .set_ack(set_ack3), .set_err(set_err3), .year(year3), .month(month3),
    .day(day3), .is_leap(is_leap3), .year_wrap(year_wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model (plain integer calendar) ----------------
  int m_y, m_m, m_d;

  function automatic bit g_leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int g_dim(int m, int y);
    int t[12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && g_leap(y)) return 29;
    return t[m-1];
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit from_bcd(logic [15:0] b, int nd, output int v);
    bit ok;
    ok = 1'b1;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return ok;
  endfunction

  task automatic model_step(input bit se, input logic [15:0] sy, input logic [7:0] sm,
                            input logic [7:0] sd, input bit tk,
                            output bit e_ack, output bit e_err, output bit e_wrap);
    int y, m, d;
    bit ok;
    e_ack = 0; e_err = 0; e_wrap = 0;
    if (se) begin
      ok = from_bcd(sy, 4, y);
      ok = from_bcd({8'h00, sm}, 2, m) && ok;
      ok = from_bcd({8'h00, sd}, 2, d) && ok;
      ok = ok && (m >= 1) && (m <= 12) && (d >= 1) && (d <= g_dim(m, y));
      if (ok) begin
        m_y = y; m_m = m; m_d = d; e_ack = 1;
      end else begin
        e_err = 1;
      end
    end else if (tk) begin
      if (m_d < g_dim(m_m, m_y)) begin
        m_d++;
      end else begin
        m_d = 1;
        if (m_m == 12) begin
          m_m = 1;
          m_y++;
          if (m_y == 10000) begin
            m_y = 0;
            e_wrap = 1;
          end
        end else begin
          m_m++;
        end
      end
    end
  endtask

  // ---------------- drive / check helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ey, input logic [7:0] em,
                           input logic [7:0] ed, input bit ea, input bit ee,
                           input bit ew, input bit el);
    $display("[%0t] %s: %h-%h-%h ack=%b err=%b wrap=%b leap=%b", $time, tag,
             year, month, day, set_ack, set_err, year_wrap, is_leap);
    chk({tag, ".year"}, 32'(year), 32'(ey));
    chk({tag, ".month"}, 32'(month), 32'(em));
    chk({tag, ".day"}, 32'(day), 32'(ed));
    chk({tag, ".ack"}, 32'(set_ack), 32'(ea));
    chk({tag, ".err"}, 32'(set_err), 32'(ee));
    chk({tag, ".wrap"}, 32'(year_wrap), 32'(ew));
    chk({tag, ".leap"}, 32'(is_leap), 32'(el));
  endtask

  task automatic check3(input string tag, input logic [11:0] ey, input logic [7:0] em,
                        input logic [7:0] ed, input bit ea, input bit ew, input bit el);
    $display("[%0t] %s: %h-%h-%h ack=%b err=%b wrap=%b leap=%b", $time, tag,
             year3, month3, day3, set_ack3, set_err3, year_wrap3, is_leap3);
    chk({tag, ".year"}, 32'(year3), 32'(ey));
    chk({tag, ".month"}, 32'(month3), 32'(em));
    chk({tag, ".day"}, 32'(day3), 32'(ed));
    chk({tag, ".ack"}, 32'(set_ack3), 32'(ea));
    chk({tag, ".wrap"}, 32'(year_wrap3), 32'(ew));
    chk({tag, ".leap"}, 32'(is_leap3), 32'(el));
  endtask

  task automatic drive(input bit se, input logic [15:0] sy, input logic [7:0] sm,
                       input logic [7:0] sd, input bit tk);
    @(negedge clk);
    set_en = se; set_year = sy; set_month = sm; set_day = sd; day_tick = tk;
    @(posedge clk);
    #1;
    set_en = 1'b0; day_tick = 1'b0;
  endtask

  task automatic drive3(input bit se, input logic [11:0] sy, input logic [7:0] sm,
                        input logic [7:0] sd, input bit tk);
    @(negedge clk);
    set_en3 = se; set_year3 = sy; set_month3 = sm; set_day3 = sd; day_tick3 = tk;
    @(posedge clk);
    #1;
    set_en3 = 1'b0; day_tick3 = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          se;
    bit          tk;
    logic [15:0] sy;
    logic [7:0]  sm;
    logic [7:0]  sd;
    logic [15:0] ey;
    logic [7:0]  em;
    logic [7:0]  ed;
    bit          ea;
    bit          ee;
    bit          ew;
    bit          el;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit se, bit tk, logic [15:0] sy, logic [7:0] sm, logic [7:0] sd,
                              logic [15:0] ey, logic [7:0] em, logic [7:0] ed,
                              bit ea, bit ee, bit ew, bit el);
    vec_t v;
    v.se = se; v.tk = tk; v.sy = sy; v.sm = sm; v.sd = sd;
    v.ey = ey; v.em = em; v.ed = ed; v.ea = ea; v.ee = ee; v.ew = ew; v.el = el;
    return v;
  endfunction

  initial begin
    bit ea, ee, ew;
    int ry, rm, rd, rdim, r;
    logic [15:0] sy;
    logic [7:0]  sm, sd;
    bit se, tk;

    //             se tk  set year   mon    day      exp year  mon    day   ack err wrap leap
    vecs.push_back(mk(1, 0, 16'h2024, 8'h02, 8'h28, 16'h2024, 8'h02, 8'h28, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2024, 8'h02, 8'h29, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2024, 8'h03, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h02, 8'h28, 16'h2023, 8'h02, 8'h28, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2023, 8'h03, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2100, 8'h02, 8'h28, 16'h2100, 8'h02, 8'h28, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2100, 8'h03, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2400, 8'h02, 8'h28, 16'h2400, 8'h02, 8'h28, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2400, 8'h02, 8'h29, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h1999, 8'h12, 8'h31, 16'h1999, 8'h12, 8'h31, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2000, 8'h01, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h12, 8'h31, 16'h2023, 8'h12, 8'h31, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2024, 8'h01, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h02, 8'h28, 16'h2023, 8'h02, 8'h28, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h02, 8'h29, 16'h2023, 8'h02, 8'h28, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h13, 8'h01, 16'h2023, 8'h02, 8'h28, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h04, 8'h31, 16'h2023, 8'h02, 8'h28, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h01, 8'h1A, 16'h2023, 8'h02, 8'h28, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h1A23, 8'h01, 8'h01, 16'h2023, 8'h02, 8'h28, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h12, 8'h00, 16'h2023, 8'h02, 8'h28, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2024, 8'h02, 8'h29, 16'h2024, 8'h02, 8'h29, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h2023, 8'h06, 8'h30, 16'h2023, 8'h06, 8'h30, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h2023, 8'h00, 8'h05, 16'h2023, 8'h06, 8'h30, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2023, 8'h07, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h09, 8'h09, 16'h2023, 8'h09, 8'h09, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2023, 8'h09, 8'h10, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h09, 8'h19, 16'h2023, 8'h09, 8'h19, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2023, 8'h09, 8'h20, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h09, 8'h29, 16'h2023, 8'h09, 8'h29, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2023, 8'h09, 8'h30, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 8'h00, 16'h2023, 8'h10, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h2023, 8'h11, 8'h31, 16'h2023, 8'h10, 8'h01, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 16'h2023, 8'h10, 8'h01, 0, 0, 0, 0));

    rst = 1'b1;
    day_tick = 0; set_en = 0; set_year = 0; set_month = 0; set_day = 0;
    day_tick3 = 0; set_en3 = 0; set_year3 = 0; set_month3 = 0; set_day3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset", 16'h2000, 8'h01, 8'h01, 0, 0, 0, 1);
    check3("reset3", 12'h000, 8'h01, 8'h01, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].se, vecs[i].sy, vecs[i].sm, vecs[i].sd, vecs[i].tk);
      check_all($sformatf("vec%0d", i), vecs[i].ey, vecs[i].em, vecs[i].ed,
                vecs[i].ea, vecs[i].ee, vecs[i].ew, vecs[i].el);
    end

    // Full rollover of the year register: wrap pulses for exactly one cycle.
    drive(1, 16'h9999, 8'h12, 8'h31, 0);
    check_all("set9999", 16'h9999, 8'h12, 8'h31, 1, 0, 0, 0);
    drive(0, 16'h0000, 8'h00, 8'h00, 1);
    check_all("wrap", 16'h0000, 8'h01, 8'h01, 0, 0, 1, 1);
    drive(0, 16'h0000, 8'h00, 8'h00, 0);
    check_all("wrap_end", 16'h0000, 8'h01, 8'h01, 0, 0, 0, 1);

    // set_en held high: each cycle is its own request.
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h2023, 8'h05, 8'h05, 0);
      check_all($sformatf("held_ok%0d", i), 16'h2023, 8'h05, 8'h05, 1, 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h2023, 8'h05, 8'h32, 0);
      check_all($sformatf("held_bad%0d", i), 16'h2023, 8'h05, 8'h05, 0, 1, 0, 0);
    end

    // Reset during a tick burst: immediate return, then ticks resume.
    drive(0, 16'h0000, 8'h00, 8'h00, 1);
    check_all("burst0", 16'h2023, 8'h05, 8'h06, 0, 0, 0, 0);
    drive(0, 16'h0000, 8'h00, 8'h00, 1);
    check_all("burst1", 16'h2023, 8'h05, 8'h07, 0, 0, 0, 0);
    @(negedge clk);
    day_tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_all("rst_async", 16'h2000, 8'h01, 8'h01, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check_all("rst_hold", 16'h2000, 8'h01, 8'h01, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    day_tick = 1'b0;
    drive(0, 16'h0000, 8'h00, 8'h00, 1);
    check_all("post_rst_tick", 16'h2000, 8'h01, 8'h02, 0, 0, 0, 1);

    // 3-digit year with implied thousands digit 2.
    check3("d3_start", 12'h000, 8'h01, 8'h01, 0, 0, 1);
    drive3(1, 12'h100, 8'h02, 8'h28, 0);
    check3("d3_set100", 12'h100, 8'h02, 8'h28, 1, 0, 0);
    drive3(0, 12'h000, 8'h00, 8'h00, 1);
    check3("d3_tick100", 12'h100, 8'h03, 8'h01, 0, 0, 0);
    drive3(1, 12'h000, 8'h02, 8'h28, 0);
    check3("d3_set000", 12'h000, 8'h02, 8'h28, 1, 0, 1);
    drive3(0, 12'h000, 8'h00, 8'h00, 1);
    check3("d3_tick000", 12'h000, 8'h02, 8'h29, 0, 0, 1);
    drive3(1, 12'h999, 8'h12, 8'h31, 0);
    check3("d3_set999", 12'h999, 8'h12, 8'h31, 1, 0, 0);
    drive3(0, 12'h000, 8'h00, 8'h00, 1);
    check3("d3_wrap", 12'h000, 8'h01, 8'h01, 0, 1, 1);

    // Randomized traffic against the integer model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_y = 2000; m_m = 1; m_d = 1;
    for (int n = 0; n < 600; n++) begin
      r  = int'($urandom_range(0, 99));
      se = (r < 15);
      tk = (r >= 10) && (r < 80);
      ry = ($urandom_range(0, 9) == 0) ? 9999 : int'($urandom_range(0, 9999));
      rm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 13)) : 12 - int'($urandom_range(0, 11));
      rdim = g_dim(rm, ry);
      if (rdim == 0) rdim = 31;
      rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : rdim - int'($urandom_range(0, 1));
      sy = to_bcd(ry);
      sm = to_bcd(rm) % 256;
      sd = to_bcd(rd) % 256;
      if ($urandom_range(0, 19) == 0) begin
        int k;
        k = int'($urandom_range(0, 3));
        sy[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      model_step(se, sy, sm, sd, tk, ea, ee, ew);
      drive(se, sy, sm, sd, tk);
      check_all($sformatf("rnd%0d", n), to_bcd(m_y), to_bcd(m_m) % 256, to_bcd(m_d) % 256,
                ea, ee, ew, g_leap(m_y));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/date_counter.md
# date_counter

Calendar date counter for the clock datapath: holds day, month and year in packed BCD and advances one day per `day_tick` from the time-of-day counter. Full Gregorian leap rule (div-4, not div-100 unless div-400), parametrised year width, validated load port. Successor to the century-limited combinational leap detector; drives the date display and alarm/calendar logic.

## Interface

Parameters:
- `YEAR_DIGITS`, 4: BCD digits in year register; 3 or 4 only.
- `THOUSANDS`, 4'h2: implied thousands digit for leap evaluation when `YEAR_DIGITS`=3; ignored when 4.
- `RESET_YEAR`, 16'h2000: reset year, BCD; low `4*YEAR_DIGITS` bits used.
- `RESET_MONTH`, 8'h01: reset month, BCD.
- `RESET_DAY`, 8'h01: reset day, BCD.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `day_tick` in 1: one-cycle strobe, advance one day.
- `set_en` in 1: load request, sampled every cycle.
- `set_year` in 4*YEAR_DIGITS: BCD year to load.
- `set_month` in 8: BCD month to load.
- `set_day` in 8: BCD day to load.
- `set_ack` out 1: pulse, load accepted.
- `set_err` out 1: pulse, load rejected.
- `year` out 4*YEAR_DIGITS: current year, BCD.
- `month` out 8: current month, BCD 01–12.
- `day` out 8: current day, BCD 01–31.
- `is_leap` out 1: current year is leap.
- `year_wrap` out 1: pulse, year rolled over from all-9s to all-0s.

## Operation

- Reset: `year/month/day` = RESET_*; `set_ack`, `set_err`, `year_wrap` = 0. RESET_* must form a valid date; elaboration assertion otherwise.
- Days in month: Feb 29 if leap else 28; Apr/Jun/Sep/Nov 30; others 31.
- Leap: full year = (thousands, hundreds, tens, ones). Two-digit value tens:ones div-4 iff (ones ∈ {0,4,8} and tens even) or (ones ∈ {2,6} and tens odd). If tens:ones ≠ 00, leap = tens:ones div-4. If 00, leap = thousands:hundreds div-4 (same rule). Thus 1900, 2100 not leap; 2000, 2400 leap.
- Tick: day < dim → day+1 with BCD carry (09→10, 19→20, 29→30). Day = dim → day 01, month+1 (09→10). Month 12 → month 01, year+1 BCD ripple. Year all-9s → all-0s, `year_wrap` pulses.
- Set: valid iff every digit ≤ 9, month 01–12, day 01..dim(set_month, set_year) with leap evaluated on `set_year`. Valid → load all three fields, `set_ack`. Invalid → no field changes, `set_err`.
- Priority: `set_en` over `day_tick`. Tick in the same cycle as `set_en` is dropped, whether the set is valid or invalid.
- `set_en` high for N cycles = N independent requests.

## Timing

- `day_tick` or `set_en` at edge k → new date, `set_ack`/`set_err`, `year_wrap` visible after edge k; pulses high exactly one cycle.
- `is_leap` is combinational from registered `year`; coherent with `year` in the same cycle.
- All other outputs registered; no comb path from inputs to outputs.
- Reset asserted mid-operation: immediate return to reset values, pending pulses cleared; first tick after deassertion is honoured normally.

## Structure

- Package `date_pkg`: BCD month constants (`M_FEB`, `M_APR`, `M_JUN`, `M_SEP`, `M_NOV`, `M_DEC`), days-in-month function (month, leap) → BCD, BCD digit-valid function.
- Sub-module `leap_year_gregorian`: combinational, 16-bit BCD year in, `is_leap` out. Instanced twice: current year and `set_year`, each padded with `THOUSANDS` when `YEAR_DIGITS`=3.
- Top: date registers, increment/carry chain, set validation, pulse registers.

## Test plan

- Reset → 2000-01-01, `is_leap`=1, all pulses 0.
- 2024-02-28, two ticks → 2024-02-29, then 2024-03-01; 2023-02-28 tick → 2023-03-01.
- 2100-02-28 tick → 2100-03-01 (`is_leap`=0); 2400-02-28 tick → 2400-02-29; `YEAR_DIGITS`=3 with year 100 → not leap, 000 → leap.
- 1999-12-31 tick → 2000-01-01, `year_wrap`=0; 9999-12-31 tick → 0000-01-01, `year_wrap`=1 for one cycle.
- Sets 2023-02-29, 2023-13-01, 2023-04-31, 2023-01-1A → `set_err` each, date unchanged; set 2024-02-29 → `set_ack`, loaded.
- `set_en` (2023-06-30) with `day_tick` same cycle → 2023-06-30, tick lost; `rst` during tick burst → 2000-01-01 next cycle.
